// File: rtl/otp_auth_engine.sv
// One-time-code authentication engine: issues a code from a free-running LFSR, collects
// DIGITS hex digits, compares them, and enforces an expiry window and a timed lockout.
module otp_auth_engine #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned EXPIRE_CYC = 1000000,
  parameter int unsigned LOCK_CYC   = 5000000,
  parameter logic [31:0] LFSR_TAPS  = 32'h8020_0003,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_ACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            user_digit,
  input  logic                  otp_latch,
  input  logic                  user_latch,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   otp,
  output logic [4*DIGITS-1:0]   user_otp,
  output logic [3:0]            digit_cnt,
  output logic [3:0]            wrng_atmpt,
  output logic                  unlock,
  output logic                  locked,
  output logic                  expired,
  output logic [2:0]            state
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned TMAX = (EXPIRE_CYC > LOCK_CYC) ? EXPIRE_CYC : LOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [W-1:0]  TAPS      = LFSR_TAPS[W-1:0];
  localparam logic [W-1:0]  SEED      = LFSR_SEED[W-1:0];
  localparam logic [TW-1:0] EXP_LAST  = TW'(EXPIRE_CYC - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYC - 1);
  localparam logic [3:0]    DIG_N     = 4'(DIGITS);
  localparam logic [3:0]    TRIES_N   = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArmed    = 3'd1,
    StCheck    = 3'd2,
    StUnlocked = 3'd3,
    StLockout  = 3'd4,
    StExpired  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  otp_q, otp_d;
  logic [W-1:0]  user_q, user_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    wrng_q, wrng_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  lfsr_q, lfsr_d;
  logic          otp_prev_q, user_prev_q;

  logic          otp_rise, user_rise;
  logic [TW-1:0] timer_inc;
  logic [3:0]    cnt_inc, wrng_inc;
  logic [W-1:0]  user_shift;

  assign otp_rise   = otp_latch & ~otp_prev_q;
  assign user_rise  = user_latch & ~user_prev_q;
  assign timer_inc  = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  assign cnt_inc    = cnt_q + 4'd1;
  assign wrng_inc   = wrng_q + 4'd1;
  // Shift-then-or keeps this legal when DIGITS == 1.
  assign user_shift = (user_q << 4) | W'(user_digit);

  always_comb begin
    state_d = state_q;
    otp_d   = otp_q;
    user_d  = user_q;
    cnt_d   = cnt_q;
    wrng_d  = wrng_q;
    timer_d = timer_q;

    if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end else begin
      lfsr_d = lfsr_q >> 1;
    end

    unique case (state_q)
      StIdle: begin
        if (otp_rise) begin
          otp_d   = lfsr_q;
          user_d  = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        timer_d = timer_inc;
        if (clear) begin
          otp_d   = '0;
          user_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (timer_q >= EXP_LAST) begin
          user_d  = '0;
          cnt_d   = '0;
          state_d = StExpired;
        end else if (user_rise) begin
          user_d = user_shift;
          cnt_d  = cnt_inc;
          if (cnt_inc == DIG_N) state_d = StCheck;
        end
      end
      StCheck: begin
        // The expiry window keeps running across a failed attempt.
        timer_d = timer_inc;
        if (user_q == otp_q) begin
          wrng_d  = '0;
          state_d = StUnlocked;
        end else begin
          wrng_d = wrng_inc;
          if (wrng_inc == TRIES_N) begin
            timer_d = '0;
            state_d = StLockout;
          end else begin
            user_d  = '0;
            cnt_d   = '0;
            state_d = StArmed;
          end
        end
      end
      StUnlocked: begin
        if (clear) begin
          otp_d   = '0;
          user_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_q >= LOCK_LAST) begin
          wrng_d  = '0;
          otp_d   = '0;
          user_d  = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_inc;
        end
      end
      StExpired: begin
        if (clear) begin
          otp_d   = '0;
          user_d  = '0;
          state_d = StIdle;
        end else if (otp_rise) begin
          otp_d   = lfsr_q;
          timer_d = '0;
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      otp_q       <= '0;
      user_q      <= '0;
      cnt_q       <= '0;
      wrng_q      <= '0;
      timer_q     <= '0;
      lfsr_q      <= SEED;
      otp_prev_q  <= 1'b0;
      user_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      otp_q       <= otp_d;
      user_q      <= user_d;
      cnt_q       <= cnt_d;
      wrng_q      <= wrng_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      otp_prev_q  <= otp_latch;
      user_prev_q <= user_latch;
    end
  end

  assign otp        = otp_q;
  assign user_otp   = user_q;
  assign digit_cnt  = cnt_q;
  assign wrng_atmpt = wrng_q;
  assign unlock     = (state_q == StUnlocked);
  assign locked     = (state_q == StLockout);
  assign expired    = (state_q == StExpired);
  assign state      = state_q;

endmodule

// File: tb/tb_otp_auth_engine.sv
// Scoreboard bench for otp_auth_engine: a 4-digit and a 6-digit instance share the
// inputs; the unused one is held in reset.
module tb_otp_auth_engine;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'h0000_ACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b1, rst6 = 1'b1;
  logic [3:0] user_digit = '0;
  logic       otp_latch = 1'b0, user_latch = 1'b0, clear = 1'b0;

  logic [15:0] otp4, user4;
  logic [23:0] otp6, user6;
  logic [3:0]  cnt4, wrng4, cnt6, wrng6;
  logic        unl4, lck4, exp4, unl6, lck6, exp6;
  logic [2:0]  st4, st6;

  otp_auth_engine #(
    .DIGITS(4), .MAX_TRIES(3), .EXPIRE_CYC(64), .LOCK_CYC(32),
    .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
  ) dut4 (
    .clk(clk), .reset(rst4), .user_digit(user_digit), .otp_latch(otp_latch),
    .user_latch(user_latch), .clear(clear), .otp(otp4), .user_otp(user4),
    .digit_cnt(cnt4), .wrng_atmpt(wrng4), .unlock(unl4), .locked(lck4),
    .expired(exp4), .state(st4)
  );

  otp_auth_engine #(
    .DIGITS(6), .MAX_TRIES(3), .EXPIRE_CYC(64), .LOCK_CYC(32),
    .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
  ) dut6 (
    .clk(clk), .reset(rst6), .user_digit(user_digit), .otp_latch(otp_latch),
    .user_latch(user_latch), .clear(clear), .otp(otp6), .user_otp(user6),
    .digit_cnt(cnt6), .wrng_atmpt(wrng6), .unlock(unl6), .locked(lck6),
    .expired(exp6), .state(st6)
  );

  bit          sel6 = 1'b0;
  logic [31:0] m_otp, m_user;
  logic [3:0]  m_cnt, m_wrng;
  logic        m_unlock, m_locked, m_expired;
  logic [2:0]  m_state;

  always_comb begin
    m_otp     = sel6 ? 32'(otp6)  : 32'(otp4);
    m_user    = sel6 ? 32'(user6) : 32'(user4);
    m_cnt     = sel6 ? cnt6  : cnt4;
    m_wrng    = sel6 ? wrng6 : wrng4;
    m_unlock  = sel6 ? unl6  : unl4;
    m_locked  = sel6 ? lck6  : lck4;
    m_expired = sel6 ? exp6  : exp4;
    m_state   = sel6 ? st6   : st4;
  end

  // Reference LFSRs, one per width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    if ((s & mask) == 32'h0) return SEED & mask;
    if (s[0]) return ((s >> 1) ^ TAPS) & mask;
    return (s >> 1) & mask;
  endfunction

  logic [31:0] ref4, ref6;
  int          cyc = 0;
  always @(posedge clk) begin
    ref4 <= rst4 ? (SEED & 32'h0000_FFFF) : lfsr_step(ref4, 16);
    ref6 <= rst6 ? (SEED & 32'h00FF_FFFF) : lfsr_step(ref6, 24);
    cyc  <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;
  sb_item_t sb_q[$];

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", sb_q.size(), 1);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, obs, it.val);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] last_otp;
  int          arm_cyc;

  // Raise otp_latch for 'hold' cycles; the OTP is captured at the first edge.
  task automatic issue_otp(input int hold);
    last_otp = sel6 ? ref6 : ref4;
    sb_push("otp_issued", last_otp);
    otp_latch = 1'b1;
    tick();
    arm_cyc = cyc;
    if (hold > 1) tick(hold - 1);
    otp_latch = 1'b0;
  endtask

  task automatic enter_code(input logic [31:0] code, input int n, input bit expect_check);
    for (int i = n - 1; i >= 0; i--) begin
      user_digit = code[4*i +: 4];
      user_latch = 1'b1;
      tick();
      if (expect_check && i == 0) check_eq("check_state", 32'(m_state), 2);
      user_latch = 1'b0;
      tick();
    end
  endtask

  logic [31:0] wrong, saved;
  int          cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, single OTP from a held level, correct entry.
    tick(2);
    check_eq("rst_state", 32'(m_state), 0);
    check_eq("rst_otp", m_otp, 0);
    check_eq("rst_outs", {m_cnt, m_wrng, m_unlock, m_locked, m_expired}, 0);
    rst4 = 1'b0;
    issue_otp(5);
    check_eq("armed_state", 32'(m_state), 1);
    sb_pop(m_otp);
    check_eq("otp_nonzero", 32'(m_otp != 0), 1);
    sb_push("user_otp_match", last_otp);
    enter_code(last_otp, 4, 1'b1);
    check_eq("unlock", 32'(m_unlock), 1);
    check_eq("unlock_wrng", 32'(m_wrng), 0);
    sb_pop(m_user);

    // 2 + 4: two wrong codes, then lockout while inputs are wiggled.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_state", 32'(m_state), 0);
    check_eq("clear_otp", m_otp, 0);
    issue_otp(1);
    sb_pop(m_otp);
    wrong = last_otp ^ 32'h1111;
    for (int k = 1; k <= 2; k++) begin
      enter_code(wrong, 4, 1'b1);
      check_eq("wrng_cnt", 32'(m_wrng), k);
      check_eq("retry_state", 32'(m_state), 1);
      check_eq("retry_otp_kept", m_otp, last_otp);
      check_eq("retry_digits", 32'(m_cnt), 0);
    end
    enter_code(wrong, 4, 1'b1);
    check_eq("lock_wrng", 32'(m_wrng), 3);
    cnt = 0;
    while (m_locked && cnt < 100) begin
      if (cnt == 4) begin
        clear = 1'b1; otp_latch = 1'b1; user_latch = 1'b1;
      end
      if (cnt == 10) begin
        clear = 1'b0; otp_latch = 1'b0; user_latch = 1'b0;
      end
      cnt++;
      tick();
    end
    check_eq("lock_cycles", cnt, 32);
    check_eq("lock_end_state", 32'(m_state), 0);
    check_eq("lock_end_wrng", 32'(m_wrng), 0);
    check_eq("lock_end_otp", m_otp, 0);

    // 3: expiry with partial entry; re-arm from EXPIRED keeps wrng_atmpt.
    issue_otp(1);
    sb_pop(m_otp);
    enter_code(last_otp ^ 32'h0F00, 4, 1'b1);
    check_eq("s3_wrng", 32'(m_wrng), 1);
    while (!m_expired && cyc - arm_cyc < 200) tick();
    check_eq("s3_expired_a", 32'(m_state), 5);
    issue_otp(1);
    sb_pop(m_otp);
    check_eq("rearm_state", 32'(m_state), 1);
    check_eq("rearm_wrng", 32'(m_wrng), 1);
    enter_code(32'h37, 2, 1'b0);
    check_eq("partial_cnt", 32'(m_cnt), 2);
    check_eq("partial_user", m_user, 32'h37);
    while (!m_expired && cyc - arm_cyc < 200) tick();
    check_eq("expire_cycles", cyc - arm_cyc, 64);
    check_eq("expire_cnt", 32'(m_cnt), 0);
    check_eq("expire_user", m_user, 0);

    // 5a: digit on the expiry edge loses.
    issue_otp(1);
    sb_pop(m_otp);
    while (cyc - arm_cyc < 63) tick();
    user_digit = 4'h5;
    user_latch = 1'b1;
    tick();
    check_eq("race_state", 32'(m_state), 5);
    check_eq("race_cnt", 32'(m_cnt), 0);
    check_eq("race_user", m_user, 0);
    user_latch = 1'b0;

    // 5b: simultaneous otp_latch and user_latch in ARMED.
    issue_otp(1);
    sb_pop(m_otp);
    saved = last_otp;
    tick();
    user_digit = 4'hA;
    otp_latch = 1'b1;
    user_latch = 1'b1;
    tick();
    check_eq("both_cnt", 32'(m_cnt), 1);
    check_eq("both_user", m_user, 32'hA);
    check_eq("both_otp_kept", m_otp, saved);
    otp_latch = 1'b0;
    user_latch = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("abort_state", 32'(m_state), 0);
    check_eq("abort_otp_user", m_otp | m_user, 0);
    check_eq("abort_wrng_kept", 32'(m_wrng), 1);

    // 6a: reset out of UNLOCKED and out of LOCKOUT.
    issue_otp(1);
    sb_pop(m_otp);
    enter_code(last_otp, 4, 1'b1);
    check_eq("s6_unlock", 32'(m_unlock), 1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check_eq("rstu_state", 32'(m_state), 0);
    check_eq("rstu_outs", m_otp | m_user | 32'({m_cnt, m_wrng, m_unlock}), 0);
    issue_otp(1);
    sb_pop(m_otp);
    for (int k = 0; k < 3; k++) enter_code(last_otp ^ 32'h0001, 4, 1'b1);
    check_eq("s6_locked", 32'(m_locked), 1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check_eq("rstl_state", 32'(m_state), 0);
    check_eq("rstl_outs", m_otp | m_user | 32'({m_cnt, m_wrng, m_locked}), 0);
    issue_otp(1);
    sb_pop(m_otp);
    check_eq("rstl_rearm", 32'(m_state), 1);

    // 6b: six-digit instance.
    rst4 = 1'b1;
    sel6 = 1'b1;
    tick();
    check_eq("d6_rst_state", 32'(m_state), 0);
    check_eq("d6_rst_otp", m_otp, 0);
    rst6 = 1'b0;
    issue_otp(5);
    check_eq("d6_armed", 32'(m_state), 1);
    sb_pop(m_otp);
    check_eq("d6_otp_nonzero", 32'(m_otp != 0), 1);
    sb_push("d6_user_match", last_otp);
    enter_code(last_otp, 6, 1'b1);
    check_eq("d6_unlock", 32'(m_unlock), 1);
    check_eq("d6_cnt", 32'(m_cnt), 6);
    check_eq("d6_wrng", 32'(m_wrng), 0);
    sb_pop(m_user);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otp_auth_engine.md
Name: otp_auth_engine

Overview:
Parametrised successor to the fixed 4-digit OTP authentication datapath. A single block issues a one-time code from an internal free-running LFSR and collects DIGITS hex digits from the user. It compares the entry, counts wrong attempts, and enforces an entry-expiry window and a timed lockout. It replaces the separate edge-detect/LFSR/FSM trio under the top level and feeds the existing 7-segment display path.

Parameters:
DIGITS, 4, OTP length in hex digits (1..8); OTP width W = 4*DIGITS
MAX_TRIES, 3, wrong attempts before lockout (1..15)
EXPIRE_CYC, 1000000, clock cycles allowed in ARMED before the OTP expires (>=2)
LOCK_CYC, 5000000, clock cycles spent in LOCKOUT (>=2)
LFSR_TAPS, 32'h8020_0003, Galois feedback mask; low W bits are used
LFSR_SEED, 32'h0000_ACE1, reset/reload value; low W bits are used and must be nonzero

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
user_digit  in  4  hex digit presented with user_latch
otp_latch  in  1  level request for a new OTP; rising edge detected internally
user_latch  in  1  level digit-enter strobe; rising edge detected internally
clear  in  1  level abort/logout; sampled every cycle
otp  out  W  currently issued OTP
user_otp  out  W  digits entered so far; newest digit in bits [3:0]
digit_cnt  out  4  number of digits entered (0..DIGITS)
wrng_atmpt  out  4  wrong-attempt count
unlock  out  1  high in UNLOCKED
locked  out  1  high in LOCKOUT
expired  out  1  high in EXPIRED
state  out  3  IDLE=0, ARMED=1, CHECK=2, UNLOCKED=3, LOCKOUT=4, EXPIRED=5

Behaviour:
- Reset, one cycle, synchronous:
  - state = IDLE; all outputs 0.
  - LFSR = SEED; timer = 0; edge registers = 0.
- Edge detect: prev <= input every cycle; rise = input & ~prev. The FSM acts at the same clock edge where rise is 1, and registered outputs update after that edge. Inputs are pre-synchronised. A held level produces exactly one rise.
- LFSR:
  - Advances every cycle in every state: s <= s[0] ? (s>>1)^TAPS : s>>1.
  - If s == 0, reload SEED.
- IDLE:
  - otp_latch rise: otp <= LFSR value; user_otp, digit_cnt and timer cleared; go to ARMED.
  - user_latch ignored.
- ARMED:
  - user_latch rise: user_otp <= {user_otp[W-5:0], user_digit}; digit_cnt++.
  - When digit_cnt reaches DIGITS, go to CHECK.
  - The timer increments every cycle. At timer == EXPIRE_CYC-1, go to EXPIRED and clear user_otp/digit_cnt; this takes priority over a same-cycle digit.
  - otp_latch ignored; the OTP cannot be re-issued while armed.
  - clear: go to IDLE; otp and user_otp cleared; wrng_atmpt preserved.
- CHECK (exactly one cycle):
  - Match: go to UNLOCKED; wrng_atmpt <= 0.
  - Mismatch: wrng_atmpt++.
    - If the new value == MAX_TRIES: go to LOCKOUT; timer <= 0.
    - Else: return to ARMED with user_otp/digit_cnt cleared, same OTP, timer not restarted.
- UNLOCKED:
  - Holds until clear, then goes to IDLE; otp and user_otp cleared.
  - All other inputs ignored.
- LOCKOUT:
  - All inputs ignored, including clear.
  - The timer counts up; at LOCK_CYC-1 go to IDLE with wrng_atmpt, otp, user_otp and digit_cnt cleared.
- EXPIRED:
  - otp_latch rise: new OTP, timer cleared, go to ARMED; wrng_atmpt preserved.
  - clear: go to IDLE.
- Priority within one cycle: reset > clear > timer expiry > user_latch > otp_latch.
- Reset mid-operation: state is lost immediately, with no residual lockout. wrng_atmpt is cleared only by reset, a successful match, or lockout completion.
- Timer width: clog2(max(EXPIRE_CYC, LOCK_CYC)) bits, saturating; it never wraps.

Test Plan:
Sim parameters for all scenarios: DIGITS=4, MAX_TRIES=3, EXPIRE_CYC=64, LOCK_CYC=32.
1. Reset, then otp_latch high for 5 cycles -> one OTP issued, otp != 0, state=1. Enter the 4 correct digits -> one CHECK cycle, then unlock=1, wrng_atmpt=0, user_otp==otp.
2. Enter a wrong code twice -> wrng_atmpt=1 then 2, state returns to 1 each time, and otp is unchanged. A third wrong code -> locked=1 for 32 cycles, then state=0, wrng_atmpt=0.
3. Arm, enter 2 digits, then idle -> 64 cycles after arming, expired=1, digit_cnt=0. otp_latch rise -> new OTP, state=1, wrng_atmpt preserved.
4. During LOCKOUT, pulse clear, otp_latch and user_latch -> no effect; locked stays 1 until the timer completes.
5. In ARMED, assert user_latch rise and the expiry cycle together -> EXPIRED wins, digit not stored. Assert otp_latch and user_latch rises together in ARMED -> digit stored, OTP unchanged.
6. Assert reset in UNLOCKED and again in LOCKOUT -> next cycle all outputs 0, state=0. Rebuild with DIGITS=6 and repeat scenario 1 -> W=24, 6 digits required.
